cprv_ex_stage: RTL
==================

CPRV_EX_STAGE -- requirements
Module: cprv_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port valid_ex_i  input  1  decoded instruction from ID is valid.
REQ-005 SHALL have port ready_ex_o  output  1  EX accepts the instruction this cycle.
REQ-006 SHALL have ports rs1_data_ex_i, rs2_data_ex_i, imm_data_ex_i  input  DATA_WIDTH  operands and immediate.
REQ-007 SHALL have ports rd_addr_ex_i 5, rd_en_ex_i 1, opcode_ex_i 7, funct3_ex_i 3, funct7_ex_i 7, mem_w_en_ex_i 1, all inputs  decoded fields.
REQ-008 SHALL have port valid_mem_o  output  1  result register holds a valid instruction for MEM.
REQ-009 SHALL have port ready_mem_i  input  1  MEM accepts the result this cycle.
REQ-010 SHALL have ports alu_data_mem_o and rs2_data_mem_o  output  DATA_WIDTH  result/address and store data.
REQ-011 SHALL have ports rd_addr_mem_o 5, rd_en_mem_o 1, funct3_mem_o 3, mem_w_en_mem_o 1, all outputs  forwarded fields.

Function
REQ-012 Handshake: transfer from ID occurs on an edge where valid_ex_i & ready_ex_o; transfer to MEM occurs on an edge where valid_mem_o & ready_mem_i.
REQ-013 ready_ex_o SHALL equal (state==IDLE) & (~valid_mem_o | ready_mem_i), computed combinationally.
REQ-014 Single-cycle operations SHALL load all *_mem_o registers on the accepting edge and set valid_mem_o, giving 1-cycle latency.
REQ-015 valid_mem_o SHALL clear on an edge where MEM accepts the result and no new result loads; every *_mem_o SHALL hold stable while valid_mem_o & ~ready_mem_i.
REQ-016 OP (0110011) and OP-IMM (0010011) SHALL compute by funct3 the operations ADD, SLL, SLT, SLTU, XOR, SRL/SRA, OR and AND on 64 bits.
- SUB is selected only for OP with funct7[5]=1; SRA is selected when funct7[5]=1.
- The second operand is rs2 for OP and imm for OP-IMM; the shift amount is operand[5:0].
REQ-017 OP-32 (0111011) and OP-IMM-32 (0011011) SHALL support ADDW, SUBW, SLLW, SRLW and SRAW on bits [31:0].
- The shift amount is operand[4:0].
- The result is the 32-bit value sign-extended to 64 bits.
REQ-018 LUI (0110111) SHALL produce imm; LOAD (0000011) and STORE (0100011) SHALL produce rs1+imm; any other opcode SHALL produce 0 with all fields passed through.
REQ-019 rs2_data_mem_o, rd_addr_mem_o, rd_en_mem_o, funct3_mem_o and mem_w_en_mem_o SHALL be copied from the inputs on the accepting edge.
REQ-020 Arithmetic SHALL wrap modulo 2^64 (or 2^32 for W ops) with no overflow flag; SLT is signed and SLTU is unsigned.

Reset
REQ-021 While rst=1, state=IDLE, valid_mem_o=0 and every *_mem_o register=0, independent of clk.
REQ-022 After rst deasserts, ready_ex_o=1 and the first valid_ex_i SHALL be accepted on the next edge.
REQ-023 Reset during a multiply SHALL abort it with no result emitted.

Configuration
REQ-024 When macro CPRV_EX_MUL_EN is defined, OP/OP-32 with funct7=0000001 and funct3=000 (MUL/MULW) SHALL use an iterative shift-add multiplier.
- States: IDLE -> MUL on the accepting edge; MUL lasts 64 cycles (counter 0..63, one multiplier bit per cycle); MUL -> DONE.
- DONE -> IDLE loads the result and sets valid_mem_o on the first edge where ~valid_mem_o | ready_mem_i.
- MUL produces the low 64 bits of the product; MULW produces sign-extended product[31:0].
- funct7=0000001 with funct3!=000 SHALL produce 0 at single-cycle latency.
REQ-025 When CPRV_EX_MUL_EN is undefined, no multiplier or MUL/DONE state SHALL exist, and funct7=0000001 SHALL decode per REQ-016/017 as a normal ALU op.

Verification
REQ-026 OP ADD, rs1=5, rs2=7 -> alu_data_mem_o=12 and valid_mem_o=1 one edge after acceptance.
REQ-027 OP-IMM-32 ADDIW, rs1=0x7FFFFFFF, imm=1 -> alu_data_mem_o=0xFFFFFFFF80000000.
REQ-028 OP-IMM SRAI, rs1=0x8000000000000000, imm=0x43F (shamt 63, bit10 set) -> alu_data_mem_o=0xFFFFFFFFFFFFFFFF.
REQ-029 Backpressure test, with two back-to-back valid instructions:
- Stimulus: hold ready_mem_i=0 for 3 cycles.
- Response: ready_ex_o=0 and outputs stable throughout; second instruction transfers on the edge where ready_mem_i=1, no loss or duplication.
REQ-030 With CPRV_EX_MUL_EN, MUL rs1=3, rs2=-2:
- ready_ex_o=0 for 64 cycles.
- Then alu_data_mem_o=0xFFFFFFFFFFFFFFFA with valid_mem_o=1.
- rst pulse at cycle 20 of a repeat -> valid_mem_o stays 0 and ready_ex_o=1 after release.

Source files
------------

// File: rtl/cprv_ex_stage.sv
// rtl/cprv_ex_stage.sv - RV64 execute stage with valid/ready handshake; optional multiplier via CPRV_EX_MUL_EN
module cprv_ex_stage #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_ex_i,
  output logic                  ready_ex_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_ex_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_ex_i,
  input  logic [DATA_WIDTH-1:0] imm_data_ex_i,
  input  logic [4:0]            rd_addr_ex_i,
  input  logic                  rd_en_ex_i,
  input  logic [6:0]            opcode_ex_i,
  input  logic [2:0]            funct3_ex_i,
  input  logic [6:0]            funct7_ex_i,
  input  logic                  mem_w_en_ex_i,
  output logic                  valid_mem_o,
  input  logic                  ready_mem_i,
  output logic [DATA_WIDTH-1:0] alu_data_mem_o,
  output logic [DATA_WIDTH-1:0] rs2_data_mem_o,
  output logic [4:0]            rd_addr_mem_o,
  output logic                  rd_en_mem_o,
  output logic [2:0]            funct3_mem_o,
  output logic                  mem_w_en_mem_o
);
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;

  logic                  accept;
  logic                  load_alu;
  logic                  is_reg_op;
  logic                  alt_op;
  logic [DATA_WIDTH-1:0] op2;
  logic [5:0]            shamt;
  logic [31:0]           op1_w;
  logic [31:0]           op2_w;
  logic [31:0]           res_w;
  logic [DATA_WIDTH-1:0] alu_result;

  // Register-register forms take rs2 as second operand, immediate forms take imm
  assign is_reg_op = (opcode_ex_i == OPC_OP) || (opcode_ex_i == OPC_OP_32);
  assign alt_op    = funct7_ex_i[5];
  assign op2       = is_reg_op ? rs2_data_ex_i : imm_data_ex_i;
  assign shamt     = op2[5:0];
  assign op1_w     = rs1_data_ex_i[31:0];
  assign op2_w     = op2[31:0];
  assign accept    = valid_ex_i && ready_ex_o;

`ifdef CPRV_EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  is_mul;
  logic                  mul_start;
  logic                  mul_load;
  logic [5:0]            mul_cnt;
  logic                  mul_word;
  logic [DATA_WIDTH-1:0] mul_mcand;
  logic [DATA_WIDTH-1:0] mul_mplier;
  logic [DATA_WIDTH-1:0] mul_acc;
  logic [DATA_WIDTH-1:0] mul_result;
  logic [DATA_WIDTH-1:0] pend_rs2;
  logic [4:0]            pend_rd_addr;
  logic                  pend_rd_en;
  logic [2:0]            pend_funct3;
  logic                  pend_mem_w_en;

  assign is_mul     = is_reg_op && (funct7_ex_i == 7'b0000001) && (funct3_ex_i == 3'b000);
  assign mul_start  = accept && is_mul;
  assign load_alu   = accept && !is_mul;
  assign mul_load   = (state_q == S_DONE) && (!valid_mem_o || ready_mem_i);
  assign ready_ex_o = (state_q == S_IDLE) && (!valid_mem_o || ready_mem_i);
  assign mul_result = mul_word ? {{(DATA_WIDTH-32){mul_acc[31]}}, mul_acc[31:0]} : mul_acc;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: 64 multiply iterations, then wait for the result slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_MUL;
      S_MUL:   if (mul_cnt == 6'd63) state_d = S_DONE;
      S_DONE:  if (mul_load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add datapath, one multiplier bit per cycle; fields parked until the result loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt       <= '0;
      mul_word      <= 1'b0;
      mul_mcand     <= '0;
      mul_mplier    <= '0;
      mul_acc       <= '0;
      pend_rs2      <= '0;
      pend_rd_addr  <= '0;
      pend_rd_en    <= 1'b0;
      pend_funct3   <= '0;
      pend_mem_w_en <= 1'b0;
    end else if (mul_start) begin
      mul_cnt       <= '0;
      mul_word      <= (opcode_ex_i == OPC_OP_32);
      mul_mcand     <= rs1_data_ex_i;
      mul_mplier    <= rs2_data_ex_i;
      mul_acc       <= '0;
      pend_rs2      <= rs2_data_ex_i;
      pend_rd_addr  <= rd_addr_ex_i;
      pend_rd_en    <= rd_en_ex_i;
      pend_funct3   <= funct3_ex_i;
      pend_mem_w_en <= mem_w_en_ex_i;
    end else if (state_q == S_MUL) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 6'd1;
    end
  end
`else
  logic unused_funct7;

  assign unused_funct7 = ^{funct7_ex_i[6], funct7_ex_i[4:0]};
  assign load_alu      = accept;
  assign ready_ex_o    = !valid_mem_o || ready_mem_i;
`endif

  // Single-cycle ALU result selected by opcode and funct3
  always_comb begin
    alu_result = '0;
    res_w      = '0;
    case (opcode_ex_i)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3_ex_i)
          3'b000: alu_result = (opcode_ex_i == OPC_OP && alt_op) ? rs1_data_ex_i - op2
                                                                 : rs1_data_ex_i + op2;
          3'b001: alu_result = rs1_data_ex_i << shamt;
          3'b010: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_data_ex_i) < $signed(op2))};
          3'b011: alu_result = {{(DATA_WIDTH-1){1'b0}}, (rs1_data_ex_i < op2)};
          3'b100: alu_result = rs1_data_ex_i ^ op2;
          3'b101: alu_result = alt_op ? $unsigned($signed(rs1_data_ex_i) >>> shamt)
                                      : rs1_data_ex_i >> shamt;
          3'b110: alu_result = rs1_data_ex_i | op2;
          default: alu_result = rs1_data_ex_i & op2;
        endcase
      end
      OPC_OP_32, OPC_OP_IMM_32: begin
        case (funct3_ex_i)
          3'b000: res_w = (opcode_ex_i == OPC_OP_32 && alt_op) ? op1_w - op2_w : op1_w + op2_w;
          3'b001: res_w = op1_w << op2_w[4:0];
          3'b101: res_w = alt_op ? $unsigned($signed(op1_w) >>> op2_w[4:0]) : op1_w >> op2_w[4:0];
          default: res_w = '0;
        endcase
        alu_result = {{(DATA_WIDTH-32){res_w[31]}}, res_w};
      end
      OPC_LUI:              alu_result = imm_data_ex_i;
      OPC_LOAD, OPC_STORE:  alu_result = rs1_data_ex_i + imm_data_ex_i;
      default:              alu_result = '0;
    endcase
`ifdef CPRV_EX_MUL_EN
    // Unsupported M-extension ops complete immediately with zero
    if (is_reg_op && funct7_ex_i == 7'b0000001 && funct3_ex_i != 3'b000) alu_result = '0;
`endif
  end

  // Result register towards MEM: load, hold under backpressure, drain when taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_mem_o    <= 1'b0;
      alu_data_mem_o <= '0;
      rs2_data_mem_o <= '0;
      rd_addr_mem_o  <= '0;
      rd_en_mem_o    <= 1'b0;
      funct3_mem_o   <= '0;
      mem_w_en_mem_o <= 1'b0;
    end else if (load_alu) begin
      valid_mem_o    <= 1'b1;
      alu_data_mem_o <= alu_result;
      rs2_data_mem_o <= rs2_data_ex_i;
      rd_addr_mem_o  <= rd_addr_ex_i;
      rd_en_mem_o    <= rd_en_ex_i;
      funct3_mem_o   <= funct3_ex_i;
      mem_w_en_mem_o <= mem_w_en_ex_i;
`ifdef CPRV_EX_MUL_EN
    end else if (mul_load) begin
      valid_mem_o    <= 1'b1;
      alu_data_mem_o <= mul_result;
      rs2_data_mem_o <= pend_rs2;
      rd_addr_mem_o  <= pend_rd_addr;
      rd_en_mem_o    <= pend_rd_en;
      funct3_mem_o   <= pend_funct3;
      mem_w_en_mem_o <= pend_mem_w_en;
`endif
    end else if (ready_mem_i) begin
      valid_mem_o <= 1'b0;
    end
  end

endmodule
